// File: rtl/float_argmax.sv
// Sequential argmax over N packed IEEE-754 single lanes, one lane compared per clock.
// Optional macro ARGMAX_VAL_EN adds the max_val output carrying the winning lane's bits.
module float_argmax #(
  parameter int S  = 32,
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [S*N-1:0] y,
  output logic [IW-1:0]  idx,
  output logic           done
`ifdef ARGMAX_VAL_EN
  ,
  output logic [S-1:0]   max_val
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           accept;
  logic [S-1:0]   lanes [N];
  logic [S-1:0]   best;
  logic [S-1:0]   lane_cur;
  logic [IW-1:0]  cnt;
  logic           last;

  // Strict "a > b" on raw single-precision bits. A NaN a never wins; a NaN b loses
  // to any non-NaN a; +0 and -0 tie so the lower lane keeps the result.
  function automatic logic gt(input logic [S-1:0] a, input logic [S-1:0] b);
    logic a_nan;
    logic b_nan;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    if (a_nan)                                 return 1'b0;
    if (b_nan)                                 return 1'b1;
    if (a[30:0] == 31'd0 && b[30:0] == 31'd0)  return 1'b0;
    if (a[31] != b[31])                        return !a[31];
    if (!a[31])                                return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  assign lane_cur = lanes[cnt];
  assign last     = (cnt == IW'(N - 1));

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, HOLD: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (N == 1) ? HOLD : SCAN;
        end
      end
      SCAN:    if (last) state_nxt = HOLD;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      done  <= 1'b0;
      best  <= '0;
      cnt   <= '0;
      // NOTE: the lane store is deliberately cleared on reset, not left as uninitialised RAM.
      for (int i = 0; i < N; i++) lanes[i] <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        for (int i = 0; i < N; i++) lanes[i] <= y[S*i +: S];
        best <= y[S-1:0];
        idx  <= '0;
        cnt  <= IW'(1);
        done <= (N == 1);
      end else if (state == SCAN) begin
        if (gt(lane_cur, best)) begin
          best <= lane_cur;
          idx  <= cnt;
        end
        if (last) done <= 1'b1;
        else      cnt  <= cnt + IW'(1);
      end
    end
  end

`ifdef ARGMAX_VAL_EN
  assign max_val = best;
`endif

endmodule

// File: tb/tb_float_argmax.sv
// Self-checking bench for float_argmax: N=1, N=2 and N=4 instances checked against a
// signed-magnitude ordering model, with directed corner vectors and random vectors.
module tb_float_argmax;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start1 = 1'b0, start2 = 1'b0, start4 = 1'b0;
  logic [31:0]  y1 = '0;
  logic [63:0]  y2 = '0;
  logic [127:0] y4 = '0;
  logic [0:0]   idx1, idx2;
  logic [1:0]   idx4;
  logic         done1, done2, done4;
`ifdef ARGMAX_VAL_EN
  logic [31:0]  mv1, mv2, mv4;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  float_argmax #(.N(1)) u1 (.clk(clk), .rst(rst), .start(start1), .y(y1), .idx(idx1), .done(done1)
`ifdef ARGMAX_VAL_EN
    , .max_val(mv1)
`endif
  );
  float_argmax #(.N(2)) u2 (.clk(clk), .rst(rst), .start(start2), .y(y2), .idx(idx2), .done(done2)
`ifdef ARGMAX_VAL_EN
    , .max_val(mv2)
`endif
  );
  float_argmax #(.N(4)) u4 (.clk(clk), .rst(rst), .start(start4), .y(y4), .idx(idx4), .done(done4)
`ifdef ARGMAX_VAL_EN
    , .max_val(mv4)
`endif
  );

  typedef struct {
    int           n;
    logic [127:0] v;
    int           ei;
    logic [31:0]  ev;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [127:0] v, input int ei, input logic [31:0] ev);
    vec_t t;
    t.n = n; t.v = v; t.ei = ei; t.ev = ev;
    return t;
  endfunction

  // Reference: rank each non-NaN lane by its signed value (-mag for negatives, so -0 == +0),
  // keep the first strictly larger one; with no non-NaN lane, lane 0 wins.
  function automatic void model(input int n, input logic [127:0] v, output int ei, output logic [31:0] ev);
    bit          found = 0;
    longint      bk = 0;
    longint      k;
    logic [31:0] l;
    ei = 0;
    ev = v[31:0];
    for (int i = 0; i < n; i++) begin
      l = v[32*i +: 32];
      if (l[30:23] == 8'hFF && l[22:0] != 23'd0) continue;
      k = l[31] ? -longint'(l[30:0]) : longint'(l[30:0]);
      if (!found || k > bk) begin
        found = 1; bk = k; ei = i; ev = l;
      end
    end
  endfunction

  function automatic logic get_done(input int n);
    case (n)
      1:       return done1;
      2:       return done2;
      default: return done4;
    endcase
  endfunction

  function automatic int get_idx(input int n);
    case (n)
      1:       return int'(idx1);
      2:       return int'(idx2);
      default: return int'(idx4);
    endcase
  endfunction

`ifdef ARGMAX_VAL_EN
  function automatic logic [31:0] get_val(input int n);
    case (n)
      1:       return mv1;
      2:       return mv2;
      default: return mv4;
    endcase
  endfunction
`endif

  task automatic drive(input int n, input logic st, input logic [127:0] v);
    case (n)
      1:       begin start1 = st; y1 = v[31:0]; end
      2:       begin start2 = st; y2 = v[63:0]; end
      default: begin start4 = st; y4 = v;       end
    endcase
  endtask

  // Pulse start with v for one edge, scramble y afterwards, then count edges until done.
  task automatic launch(input int n, input logic [127:0] v, output int k, output bit to);
    @(negedge clk);
    drive(n, 1'b1, v);
    @(negedge clk);
    drive(n, 1'b0, {$urandom, $urandom, $urandom, $urandom});
    k  = 0;
    to = 0;
    while (!get_done(n)) begin
      if (k >= 16) begin to = 1; break; end
      @(negedge clk);
      k++;
    end
  endtask

  function automatic logic [31:0] rand_lane();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: r = {r[31], 8'hFF, (r[22:0] == 23'd0) ? 23'd1 : r[22:0]};
      1: r = {r[31], 8'hFF, 23'd0};
      2: r = {r[31], 31'd0};
      3: r = {r[31], 8'h00, r[22:0]};
      4: r = {r[31], 8'h7F, 15'd0, r[7:0]};
      default: ;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int n = 1; n <= 4; n *= 2) begin
      checks++;
      if (get_done(n) !== 1'b0 || get_idx(n) != 0) begin
        failures++;
        $display("FAIL reset n=%0d: done=%b idx=%0d, required done=0 idx=0", n, get_done(n), get_idx(n));
      end
`ifdef ARGMAX_VAL_EN
      checks++;
      if (get_val(n) !== 32'h0) begin
        failures++;
        $display("FAIL reset_val n=%0d: max_val=%h, required 00000000", n, get_val(n));
      end
`endif
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    vec_t tab[$];
    int   k;
    bit   to;
    tab.push_back(mk(2, {64'h0, 32'h3F000000, 32'h3F800000}, 0, 32'h3F800000));
    tab.push_back(mk(2, {64'h0, 32'h3F400000, 32'h3F000000}, 1, 32'h3F400000));
    tab.push_back(mk(2, {64'h0, 32'h3F400000, 32'h3F400000}, 0, 32'h3F400000));
    tab.push_back(mk(4, {32'hC0000000, 32'h00000000, 32'h80000000, 32'hBF800000}, 1, 32'h80000000));
    tab.push_back(mk(2, {64'h0, 32'h3E800000, 32'h7FC00000}, 1, 32'h3E800000));
    tab.push_back(mk(2, {64'h0, 32'h7FC00000, 32'h7FC00000}, 0, 32'h7FC00000));
    tab.push_back(mk(2, {64'h0, 32'h7FC00000, 32'h7F800000}, 0, 32'h7F800000));
    tab.push_back(mk(1, {96'h0, 32'h40000000}, 0, 32'h40000000));
    tab.push_back(mk(4, {32'hFF800000, 32'hC0000000, 32'hBF800000, 32'hC0400000}, 1, 32'hBF800000));
    tab.push_back(mk(2, {64'h0, 32'h00000002, 32'h00000001}, 1, 32'h00000002));
    tab.push_back(mk(4, {32'hFFC00000, 32'hBF800000, 32'hC0000000, 32'h7FC00001}, 2, 32'hBF800000));
    foreach (tab[t]) begin
      launch(tab[t].n, tab[t].v, k, to);
      checks++;
      if (to || k != tab[t].n - 1) begin
        failures++;
        $display("FAIL dir_latency #%0d: edges=%0d timeout=%0b, required %0d", t, k, to, tab[t].n - 1);
      end
      checks++;
      if (get_idx(tab[t].n) != tab[t].ei) begin
        failures++;
        $display("FAIL dir_idx #%0d: idx=%0d, required %0d", t, get_idx(tab[t].n), tab[t].ei);
      end
`ifdef ARGMAX_VAL_EN
      checks++;
      if (get_val(tab[t].n) !== tab[t].ev) begin
        failures++;
        $display("FAIL dir_val #%0d: max_val=%h, required %h", t, get_val(tab[t].n), tab[t].ev);
      end
`endif
    end
  endtask

  task automatic test_random();
    logic [127:0] v;
    logic [31:0]  ev;
    int           ei, k, n;
    bit           to;
    for (int it = 0; it < 150; it++) begin
      n = (it % 3 == 0) ? 4 : ((it % 3 == 1) ? 2 : 1);
      for (int i = 0; i < 4; i++) v[32*i +: 32] = rand_lane();
      if ($urandom_range(0, 4) == 0) v[32*(n-1) +: 32] = v[31:0];
      model(n, v, ei, ev);
      launch(n, v, k, to);
      checks++;
      if (to || k != n - 1 || get_idx(n) != ei) begin
        failures++;
        $display("FAIL rand #%0d n=%0d v=%h: idx=%0d edges=%0d, required idx=%0d edges=%0d",
                 it, n, v, get_idx(n), k, ei, n - 1);
      end
`ifdef ARGMAX_VAL_EN
      checks++;
      if (get_val(n) !== ev) begin
        failures++;
        $display("FAIL rand_val #%0d n=%0d: max_val=%h, required %h", it, n, get_val(n), ev);
      end
`endif
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [127:0] va, vb;
    int           k;
    bit           to;
    va = {32'h3E800000, 32'h3E000000, 32'h40000000, 32'h3F000000};
    @(negedge clk);
    drive(4, 1'b1, va);
    @(negedge clk);                    // E0 accepted
    drive(4, 1'b0, va);
    @(negedge clk);                    // first SCAN edge moved idx to lane 1
    checks++;
    if (idx4 !== 2'd1 || done4 !== 1'b0) begin
      failures++;
      $display("FAIL midscan_progress: idx=%0d done=%b, required idx=1 done=0", idx4, done4);
    end
    rst = 1'b1;
    @(negedge clk);                    // reset sampled on the second SCAN edge
    rst = 1'b0;
    checks++;
    if (idx4 !== 2'd0 || done4 !== 1'b0) begin
      failures++;
      $display("FAIL midscan_reset: idx=%0d done=%b, required idx=0 done=0", idx4, done4);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (done4 !== 1'b0) begin
      failures++;
      $display("FAIL midscan_idle: done=%b, required 0", done4);
    end
    vb = {32'h3F7FFFFF, 32'h3F000000, 32'h3F000000, 32'h3F000000};
    launch(4, vb, k, to);
    checks++;
    if (to || k != 3 || idx4 !== 2'd3) begin
      failures++;
      $display("FAIL after_reset: idx=%0d edges=%0d, required idx=3 edges=3", idx4, k);
    end
  endtask

  task automatic test_start_in_scan();
    logic [127:0] va, vb;
    int           k;
    va = {32'h3F000000, 32'h40400000, 32'hBF800000, 32'h00000000};
    vb = {32'h7F000000, 32'h00000000, 32'h00000000, 32'h00000000};
    @(negedge clk);
    drive(4, 1'b1, va);
    @(negedge clk);
    drive(4, 1'b1, vb);                // second start arrives while scanning
    @(negedge clk);
    drive(4, 1'b0, vb);
    k = 1;
    while (!done4 && k < 16) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != 3 || idx4 !== 2'd2) begin
      failures++;
      $display("FAIL start_in_scan: idx=%0d edges=%0d, required idx=2 edges=3", idx4, k);
    end
`ifdef ARGMAX_VAL_EN
    checks++;
    if (mv4 !== 32'h40400000) begin
      failures++;
      $display("FAIL start_in_scan_val: max_val=%h, required 40400000", mv4);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [127:0] va, vb;
    int           k;
    bit           to;
    va = {32'h3F000000, 32'h3F800000, 32'h3F000000, 32'h3F000000};
    vb = {32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h40800000};
    launch(4, va, k, to);
    repeat (3) @(negedge clk);
    checks++;
    if (done4 !== 1'b1 || idx4 !== 2'd2) begin
      failures++;
      $display("FAIL done_hold: done=%b idx=%0d, required done=1 idx=2", done4, idx4);
    end
    drive(4, 1'b1, vb);
    @(negedge clk);                    // start accepted from DONE
    drive(4, 1'b0, va);
    checks++;
    if (done4 !== 1'b0) begin
      failures++;
      $display("FAIL restart_drop: done=%b, required 0", done4);
    end
    k = 0;
    while (!done4 && k < 16) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != 3 || idx4 !== 2'd0) begin
      failures++;
      $display("FAIL restart_result: idx=%0d edges=%0d, required idx=0 edges=3", idx4, k);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_scan();
    test_start_in_scan();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
